sm_arith_unit: RTL and testbench

Parametrised, pipelined sign-magnitude add/subtract unit for the ALU datapath. It accepts two WIDTH-bit sign-magnitude operands and an operation code over a valid/ready handshake, and returns a sign-magnitude result with overflow and zero flags after two cycles. Overflow handling is selectable: saturate or wrap. A sticky overflow flag and a saturating overflow-event counter are provided for status readback.

---
 rtl/sm_arith_pkg.sv | 36 +++
 rtl/sm_arith_unit_if.sv | 25 ++
 rtl/sm_to_tc.sv | 12 +
 rtl/sm_arith_unit.sv | 99 +++++++++
 tb/tb_sm_arith_unit.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/sm_arith_pkg.sv
// rtl/sm_arith_pkg.sv - shared op codes and sign-magnitude/two's-complement helpers
package sm_arith_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Helpers work on a fixed wide carrier; callers pass their width and cast the result down.
    localparam int MAX_W = 64;

    function automatic logic [MAX_W:0] sm_to_tc_f(input logic [MAX_W-1:0] sm, input int w);
        logic [MAX_W:0] mag;
        logic           neg;
        mag = '0;
        neg = 1'b0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w - 1) mag[i] = sm[i];
            if (i == w - 1) neg = sm[i];
        end
        return neg ? -mag : mag;
    endfunction

    function automatic logic [MAX_W:0] tc_to_mag_f(input logic [MAX_W:0] tc, input int w);
        logic [MAX_W:0] ext;
        logic           neg;
        ext = tc;
        neg = 1'b0;
        for (int i = 0; i <= MAX_W; i++) begin
            if (i == w) neg = tc[i];
        end
        for (int i = 0; i <= MAX_W; i++) begin
            if (i > w) ext[i] = neg;
        end
        return neg ? -ext : ext;
    endfunction

endpackage

// File: rtl/sm_arith_unit_if.sv
// rtl/sm_arith_unit_if.sv - operand/result handshake bundle for sm_arith_unit
interface sm_arith_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_res, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_res, out_ovf, out_zero
    );
endinterface

// File: rtl/sm_to_tc.sv
// rtl/sm_to_tc.sv - sign-magnitude to (WIDTH+1)-bit two's-complement converter
module sm_to_tc
    import sm_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] sm,
    output logic [WIDTH:0]   tc
);
    // Negative zero maps to +0 because -0 is 0 in two's complement.
    assign tc = (WIDTH+1)'(sm_to_tc_f(MAX_W'(sm), WIDTH));
endmodule

// File: rtl/sm_arith_unit.sv
// rtl/sm_arith_unit.sv - two-stage sign-magnitude add/sub with saturate/wrap and overflow status
module sm_arith_unit
    import sm_arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    sm_arith_unit_if.slave   bus,
    input  logic             clr_sticky,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count
);
    localparam logic [WIDTH-2:0] MAXM = '1;

    logic [WIDTH:0]   a_tc;
    logic [WIDTH:0]   b_tc;
    logic [WIDTH:0]   sum;
    logic             s1_valid;
    logic [WIDTH:0]   s1_r;
    logic             s2_valid;
    logic [WIDTH-1:0] s2_res;
    logic             s2_ovf;
    logic             s2_zero;
    logic             s1_en;
    logic             s2_en;
    logic [WIDTH-1:0] r_abs;
    logic             r_ovf;
    logic [WIDTH-2:0] mag;
    logic             res_sign;
    logic             hs_ovf;

    sm_to_tc #(.WIDTH(WIDTH)) u_a_conv (.sm(bus.in_a), .tc(a_tc));
    sm_to_tc #(.WIDTH(WIDTH)) u_b_conv (.sm(bus.in_b), .tc(b_tc));

    // WIDTH+1 bits hold +-2*MAXM exactly, so the add itself never overflows.
    assign sum = (bus.in_op == OP_SUB) ? (a_tc - b_tc) : (a_tc + b_tc);

    assign s2_en        = !s2_valid || bus.out_ready;
    assign s1_en        = !s1_valid || s2_en;
    assign bus.in_ready = s1_en;

    // |R| peaks at 2*MAXM, so its top bit alone flags magnitude overflow.
    assign r_abs    = WIDTH'(tc_to_mag_f((MAX_W+1)'(s1_r), WIDTH));
    assign r_ovf    = r_abs[WIDTH-1];
    assign mag      = (r_ovf && SAT) ? MAXM : r_abs[WIDTH-2:0];
    assign res_sign = s1_r[WIDTH] && (mag != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_ovf   <= 1'b0;
            s2_zero  <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) s1_r <= sum;
            end
            if (s2_en) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_res  <= {res_sign, mag};
                    s2_ovf  <= r_ovf;
                    s2_zero <= (mag == '0);
                end
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_res   = s2_res;
    assign bus.out_ovf   = s2_ovf;
    assign bus.out_zero  = s2_zero;

    assign hs_ovf = s2_valid && bus.out_ready && s2_ovf;

    // An overflowing delivery beats a simultaneous clear: the clear applies first, then the event counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end else if (hs_ovf) begin
            ovf_sticky <= 1'b1;
            if (clr_sticky) begin
                ovf_count <= CNT_W'(1);
            end else if (ovf_count != '1) begin
                ovf_count <= ovf_count + 1'b1;
            end
        end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end
    end
endmodule

// File: tb/tb_sm_arith_unit.sv
// tb/tb_sm_arith_unit.sv - directed self-checking bench for sm_arith_unit
module tb_sm_arith_unit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       in_op;
    logic       out_ready;
    logic       clr_sticky;
    logic       st_s, st_w, st_c;
    logic [7:0] cnt_s, cnt_w;
    logic [1:0] cnt_c;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    sm_arith_unit_if #(.WIDTH(4)) if_s ();
    sm_arith_unit_if #(.WIDTH(4)) if_w ();
    sm_arith_unit_if #(.WIDTH(4)) if_c ();

    assign if_s.in_valid = in_valid;  assign if_s.in_a = in_a;  assign if_s.in_b = in_b;
    assign if_s.in_op = in_op;        assign if_s.out_ready = out_ready;
    assign if_w.in_valid = in_valid;  assign if_w.in_a = in_a;  assign if_w.in_b = in_b;
    assign if_w.in_op = in_op;        assign if_w.out_ready = out_ready;
    assign if_c.in_valid = in_valid;  assign if_c.in_a = in_a;  assign if_c.in_b = in_b;
    assign if_c.in_op = in_op;        assign if_c.out_ready = out_ready;

    sm_arith_unit #(.WIDTH(4), .SAT(1'b1), .CNT_W(8)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(if_s), .clr_sticky(clr_sticky),
        .ovf_sticky(st_s), .ovf_count(cnt_s));
    sm_arith_unit #(.WIDTH(4), .SAT(1'b0), .CNT_W(8)) u_wrap (
        .clk(clk), .rst_n(rst_n), .bus(if_w), .clr_sticky(clr_sticky),
        .ovf_sticky(st_w), .ovf_count(cnt_w));
    sm_arith_unit #(.WIDTH(4), .SAT(1'b1), .CNT_W(2)) u_cnt (
        .clk(clk), .rst_n(rst_n), .bus(if_c), .clr_sticky(clr_sticky),
        .ovf_sticky(st_c), .ovf_count(cnt_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic op);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        step();
        in_valid = 1'b0;
    endtask

    logic [3:0] sa [6];
    logic [3:0] sb [6];
    logic       so [6];
    logic [3:0] sr [6];
    int         sent;
    int         rcv;
    logic       acc;

    initial begin
        sa = '{4'b0001, 4'b0110, 4'b1010, 4'b0011, 4'b1100, 4'b0101};
        sb = '{4'b0010, 4'b0010, 4'b0001, 4'b0110, 4'b1110, 4'b0001};
        so = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b1,    1'b0};
        sr = '{4'b0011, 4'b0100, 4'b1001, 4'b1011, 4'b0010, 4'b0110};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0;
        out_ready = 1'b1; clr_sticky = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();

        chk("rst_out_valid", if_s.out_valid, 0);
        chk("rst_out_res",   if_s.out_res, 0);
        chk("rst_out_flags", {if_s.out_ovf, if_s.out_zero}, 0);
        chk("rst_status",    {st_s, cnt_s}, 0);
        chk("rst_in_ready",  if_s.in_ready, 1);

        // +5 + -3 = +2, with latency check
        send(4'b0101, 4'b1011, 1'b0);
        chk("add_lat_not_yet", if_s.out_valid, 0);
        step();
        chk("add_valid", if_s.out_valid, 1);
        chk("add_res",   if_s.out_res, 4'b0010);
        chk("add_flags", {if_s.out_ovf, if_s.out_zero}, 2'b00);
        chk("add_res_wrap", if_w.out_res, 4'b0010);
        step();

        // +5 - (-3) = +8 overflows
        send(4'b0101, 4'b1011, 1'b1);
        step();
        chk("sub_ovf_sat_res",   if_s.out_res, 4'b0111);
        chk("sub_ovf_sat_flags", {if_s.out_ovf, if_s.out_zero}, 2'b10);
        chk("sub_ovf_wrap_res",  if_w.out_res, 4'b0000);
        chk("sub_ovf_wrap_flags", {if_w.out_ovf, if_w.out_zero}, 2'b11);
        step();
        chk("sub_ovf_sticky", st_s, 1);
        chk("sub_ovf_count",  cnt_s, 1);

        // -7 + -7 = -14
        send(4'b1111, 4'b1111, 1'b0);
        step();
        chk("neg_ovf_sat_res",  if_s.out_res, 4'b1111);
        chk("neg_ovf_wrap_res", if_w.out_res, 4'b1110);
        chk("neg_ovf_wrap_ovf", if_w.out_ovf, 1);
        step();
        chk("neg_ovf_count", cnt_w, 2);

        // zero results, incl. negative zero inputs
        send(4'b0011, 4'b1011, 1'b0);
        step();
        chk("zero_a_res",   if_s.out_res, 4'b0000);
        chk("zero_a_flags", {if_s.out_ovf, if_s.out_zero}, 2'b01);
        step();
        send(4'b1000, 4'b1000, 1'b0);
        step();
        chk("negzero_res",  if_s.out_res, 4'b0000);
        chk("negzero_flag", if_s.out_zero, 1);
        step();

        // stream of 6 with out_ready low in cycles 2..5
        sent = 0;
        rcv  = 0;
        for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 5);
            in_valid  = (sent < 6);
            if (sent < 6) begin
                in_a  = sa[sent];
                in_b  = sb[sent];
                in_op = so[sent];
            end
            #1;
            if (cyc == 2) chk("stream_in_ready_full", if_s.in_ready, 0);
            acc = in_valid && if_s.in_ready;
            if (if_s.out_valid) begin
                chk("stream_res", if_s.out_res, sr[rcv]);
                if (out_ready) rcv++;
            end
            step();
            if (acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_delivered", rcv, 6);
        chk("stream_sent", sent, 6);
        step();

        // clear coinciding with an overflowing handshake: set wins
        send(4'b0101, 4'b1011, 1'b1);
        step();
        chk("coinc_pre_ovf", if_s.out_ovf, 1);
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        chk("coinc_sticky", st_s, 1);
        chk("coinc_count",  cnt_s, 1);
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        chk("clear_status", {st_s, cnt_s}, 0);
        chk("clear_status_c", {st_c, cnt_c}, 0);

        // five overflows: 2-bit counter saturates at 3
        for (int k = 0; k < 5; k++) begin
            send(4'b0111, 4'b0001, 1'b0);
            step();
            step();
        end
        chk("sat_cnt_c", cnt_c, 2'd3);
        chk("sat_cnt_s", cnt_s, 8'd5);

        // reset with two items in flight
        in_valid = 1'b1; in_a = 4'b0101; in_b = 4'b1011; in_op = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        chk("pre_rst_valid", if_s.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",  if_s.out_valid, 0);
        chk("mid_rst_status", {st_s, cnt_s}, 0);
        chk("mid_rst_ready",  if_s.in_ready, 1);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_no_stale", if_s.out_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
